// File: rtl/multi_one_shot.sv
// Multi-channel one-shot pulse generator: per-channel edge detect feeding an IDLE/FIRE/HOLD FSM.
// Optional input synchroniser enabled by defining MULTI_ONE_SHOT_SYNC_EN.
module multi_one_shot #(
    parameter int CHANNELS    = 4,
    parameter int LEN_W       = 4,
    parameter int HOLDOFF     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pulse,
    input  logic [LEN_W-1:0]    len,
    input  logic                retrig,
    input  logic                edge_sel,
    output logic [CHANNELS-1:0] out,
    output logic                busy
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int CNT_W  = (HOLD_W > LEN_W) ? HOLD_W : LEN_W;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    if (CHANNELS < 1 || LEN_W < 1 || HOLDOFF < 0 || SYNC_STAGES < 1) begin : g_bad_params
        $error("multi_one_shot: illegal parameter combination");
    end

    logic [CHANNELS-1:0] sampled;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] trigger;
    logic                len_ok;
    logic [CNT_W-1:0]    len_load;

    state_t           state     [CHANNELS];
    state_t           state_nxt [CHANNELS];
    logic [CNT_W-1:0] cnt       [CHANNELS];
    logic [CNT_W-1:0] cnt_nxt   [CHANNELS];

    logic [CHANNELS-1:0] out_nxt;
    logic                busy_nxt;

`ifdef MULTI_ONE_SHOT_SYNC_EN
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pulse;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sampled = sync_q[SYNC_STAGES-1];
`else
    assign sampled = pulse;
`endif

    // prev resets to 0 so an input already high at reset release counts as a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            prev <= sampled;
        end
    end

    assign trigger  = edge_sel ? (~sampled & prev) : (sampled & ~prev);
    assign len_ok   = (len != '0);
    assign len_load = CNT_W'(len) - CNT_W'(1);

    // NOTE: the per-channel counters are reset along with the FSMs, so a mid-pulse reset leaves no stale count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            unique case (state[i])
                IDLE: begin
                    if (trigger[i] && len_ok) begin
                        state_nxt[i] = FIRE;
                        cnt_nxt[i]   = len_load;
                    end
                end
                FIRE: begin
                    // A retrigger wins even on the last FIRE cycle.
                    if (retrig && trigger[i] && len_ok) begin
                        cnt_nxt[i] = len_load;
                    end else if (cnt[i] == '0) begin
                        if (HOLDOFF > 0) begin
                            state_nxt[i] = HOLD;
                            cnt_nxt[i]   = HOLD_LOAD;
                        end else begin
                            state_nxt[i] = IDLE;
                        end
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt[i] == '0) begin
                        state_nxt[i] = IDLE;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they track the state register exactly.
    always_comb begin
        out_nxt  = '0;
        busy_nxt = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_nxt[i] = (state_nxt[i] == FIRE);
            busy_nxt   = busy_nxt | (state_nxt[i] != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            busy <= 1'b0;
        end else begin
            out  <= out_nxt;
            busy <= busy_nxt;
        end
    end

endmodule
